frame_tx: RTL

//  Frame transmitter: source end of the valid/sop/eop frame interface. Takes frame-length

---
 rtl/frame_tx_pkg.sv | 26 ++
 rtl/frame_tx_gap_timer.sv | 34 +++
 rtl/frame_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: shared types, default widths and small helpers for the frame
// transmitter. The inter-frame gap feature is enabled with FRAME_TX_IFG_EN.
package frame_tx_pkg;

  localparam int LEN_W_DEF = 8;
  localparam int SEQ_W_DEF = 4;
  localparam int IFG_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  // The IDLE->BURST handoff already contributes one idle cycle, so a GAP
  // state is only needed when more than one idle cycle is required.
  function automatic bit gap_state_used(input int ifg);
    return ifg > 1;
  endfunction

  // Width of the gap down-counter, which holds IFG-2 at most.
  function automatic int gap_cnt_width(input int ifg);
    return (ifg > 2) ? $clog2(ifg - 1) : 1;
  endfunction

endpackage

// File: rtl/frame_tx_gap_timer.sv
// frame_tx_gap_timer: inter-frame gap down-counter, present only when
// FRAME_TX_IFG_EN is defined. Loaded on the last beat of a frame; done_o
// marks the final GAP cycle.
module frame_tx_gap_timer
  import frame_tx_pkg::*;
#(
  parameter int IFG = IFG_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CNT_W = gap_cnt_width(IFG);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(IFG - 2);

  logic [CNT_W-1:0] cnt_q;

  // Count down once per GAP cycle from the value loaded at the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/frame_tx.sv
// frame_tx: frame source for the valid/sop/eop interface. Accepts length
// requests over valid/ready and emits one beat per unpaused cycle.
// Optional feature: FRAME_TX_IFG_EN inserts IFG idle cycles between frames.
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int SEQ_W = SEQ_W_DEF,
  parameter int IFG   = IFG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  input  logic             tx_pause,
  output logic             valid_out,
  output logic             sop_out,
  output logic             eop_out,
  output logic [LEN_W-1:0] data_out,
  output logic [SEQ_W-1:0] seq_out,
  output logic             busy
);

`ifdef FRAME_TX_IFG_EN
  localparam bit IFG_ON = 1'b1;
`else
  localparam bit IFG_ON = 1'b0;
`endif
  // With IFG=0 the gap feature collapses to back-to-back behaviour.
  localparam bit USE_GAP       = IFG_ON && gap_state_used(IFG);
  localparam bit READY_ON_LAST = !IFG_ON || (IFG == 0);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, beat_cnt_q, data_q;
  logic [SEQ_W-1:0] seq_q, seq_cnt_q;
  logic             valid_q, sop_q, eop_q;
  logic             last_beat, accept;

  assign last_beat = (state_q == BURST) && !tx_pause && (beat_cnt_q == len_q);
  assign accept    = req_valid && req_ready;

`ifdef FRAME_TX_IFG_EN
  logic gap_done;

  frame_tx_gap_timer #(.IFG(IFG)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (last_beat && USE_GAP),
    .en_i   (state_q == GAP),
    .done_o (gap_done)
  );
`endif

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BURST;
      BURST:   if (last_beat && !accept) state_d = USE_GAP ? GAP : IDLE;
`ifdef FRAME_TX_IFG_EN
      GAP:     if (gap_done) state_d = IDLE;
`else
      GAP:     state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs; req_ready is held low during reset.
  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      if (state_q == IDLE)                 req_ready = 1'b1;
      else if (last_beat && READY_ON_LAST) req_ready = 1'b1;
    end
    busy = (state_q != IDLE);
  end

  // Beat datapath: registered beat outputs, beat counter and sequence numbering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      beat_cnt_q <= '0;
      data_q     <= '0;
      seq_q      <= '0;
      seq_cnt_q  <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      if (state_q == IDLE && accept) begin
        len_q      <= req_len;
        beat_cnt_q <= '0;
      end else if (state_q == BURST && !tx_pause) begin
        valid_q <= 1'b1;
        sop_q   <= (beat_cnt_q == '0);
        eop_q   <= last_beat;
        data_q  <= beat_cnt_q;
        if (beat_cnt_q == '0) seq_q <= seq_cnt_q;
        if (last_beat) begin
          seq_cnt_q  <= seq_cnt_q + 1'b1;
          beat_cnt_q <= '0;
          if (accept) len_q <= req_len;
        end else begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
        end
      end
    end
  end

  assign valid_out = valid_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;
  assign data_out  = data_q;
  assign seq_out   = seq_q;

endmodule
